// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state type, default width and overflow helper.
package serial_subtractor_pkg;

    localparam int unsigned DEFAULT_LENGTH = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Signed overflow: operand signs differ and result sign flips from a.
    function automatic logic ovf_calc(
        input logic a_msb,
        input logic b_msb,
        input logic d_msb
    );
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a requester and the serial subtractor.
// Master issues operands and start; slave returns status and result.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned LENGTH = DEFAULT_LENGTH
);

    logic              start_i;
    logic [LENGTH-1:0] a_i;
    logic [LENGTH-1:0] b_i;
    logic              busy_o;
    logic              done_o;
    logic [LENGTH-1:0] d_o;
    logic              borrow_o;
    logic              ovf_o;

    modport master (
        output start_i,
        output a_i,
        output b_i,
        input  busy_o,
        input  done_o,
        input  d_o,
        input  borrow_o,
        input  ovf_o
    );

    modport slave (
        input  start_i,
        input  a_i,
        input  b_i,
        output busy_o,
        output done_o,
        output d_o,
        output borrow_o,
        output ovf_o
    );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: diff and borrow-out of a - b - borrow_in.
// Purely combinational; used once per cycle by the serial datapath.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit per clock, LSB first, LENGTH cycles.
// Result, final borrow and signed overflow update with a done pulse.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned LENGTH = DEFAULT_LENGTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    serial_subtractor_if.slave bus
);

    localparam int unsigned CW = $clog2(LENGTH);
    localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              last;

    logic [LENGTH-1:0] a_sr;
    logic [LENGTH-1:0] b_sr;
    logic [LENGTH-1:0] d_sr;
    logic [CW-1:0]     cnt;
    logic              borrow_q;

    logic [LENGTH-1:0] d_q;
    logic              borrow_res;
    logic              ovf_q;
    logic              done_q;

    logic              bit_diff;
    logic              bit_borrow;
    logic [LENGTH-1:0] d_full;

    full_subtractor u_fs (
        .a          (a_sr[0]),
        .b          (b_sr[0]),
        .borrow_in  (borrow_q),
        .diff       (bit_diff),
        .borrow_out (bit_borrow)
    );

    // Difference shifts in from the top so bit 0 lands at LSB after LENGTH steps.
    assign d_full = {bit_diff, d_sr[LENGTH-1:1]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start_i) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_sr     <= '0;
            b_sr     <= '0;
            d_sr     <= '0;
            cnt      <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_sr     <= bus.a_i;
            b_sr     <= bus.b_i;
            d_sr     <= '0;
            cnt      <= '0;
            borrow_q <= 1'b0;
        end else if (state == RUN) begin
            a_sr     <= a_sr >> 1;
            b_sr     <= b_sr >> 1;
            d_sr     <= d_full;
            borrow_q <= bit_borrow;
            if (!last) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // On the final step a_sr[0]/b_sr[0] hold the operand sign bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q        <= '0;
            borrow_res <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (last) begin
                d_q        <= d_full;
                borrow_res <= bit_borrow;
                ovf_q      <= ovf_calc(a_sr[0], b_sr[0], bit_diff);
                done_q     <= 1'b1;
            end
        end
    end

    assign bus.busy_o   = (state == RUN);
    assign bus.done_o   = done_q;
    assign bus.d_o      = d_q;
    assign bus.borrow_o = borrow_res;
    assign bus.ovf_o    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor with an arithmetic reference.
// Driver pushes expected results; a negedge monitor pops and compares.
module tb_serial_subtractor;

    localparam int L = 16;

    typedef struct {
        logic [L-1:0] d;
        logic         br;
        logic         ov;
        int           due;
    } exp_t;

    logic clk_i;
    logic rst_ni;
    int   cyc;
    int   last_acc;
    int   errors;
    int   checks;
    exp_t sb[$];

    serial_subtractor_if #(.LENGTH(L)) bus ();

    serial_subtractor #(.LENGTH(L)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d",
                     name, act, req, cyc);
        end
    endtask

    // Reference: plain modular, unsigned and signed integer arithmetic.
    function automatic exp_t model(input logic [L-1:0] a, input logic [L-1:0] b);
        exp_t e;
        int   sa;
        int   sbv;
        int   r;
        e.d = a - b;
        e.br = (a < b);
        sa = $signed(a);
        sbv = $signed(b);
        r = sa - sbv;
        e.ov = (r > (2 ** (L - 1)) - 1) || (r < -(2 ** (L - 1)));
        e.due = 0;
        return e;
    endfunction

    // Acceptance decided from the bench's own timeline: idle 16 cycles after accept.
    task automatic issue(input logic [L-1:0] a, input logic [L-1:0] b,
                         input bit wait_idle);
        exp_t e;
        @(negedge clk_i);
        if (wait_idle) begin
            while (cyc - last_acc < L) @(negedge clk_i);
        end
        bus.start_i = 1'b1;
        bus.a_i = a;
        bus.b_i = b;
        if (cyc - last_acc >= L) begin
            last_acc = cyc + 1;
            e = model(a, b);
            e.due = cyc + 1 + L;
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
        bus.start_i = 1'b0;
        bus.a_i = L'($urandom);
        bus.b_i = L'($urandom);
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        bit   exp_busy;
        if (rst_ni) begin
            exp_busy = (sb.size() > 0) && (sb[0].due - cyc >= 1) &&
                       (sb[0].due - cyc <= L);
            chk("busy", 32'(bus.busy_o), 32'(exp_busy));
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("done", 32'(bus.done_o), 32'd1);
                chk("d", 32'(bus.d_o), 32'(e.d));
                chk("borrow", 32'(bus.borrow_o), 32'(e.br));
                chk("ovf", 32'(bus.ovf_o), 32'(e.ov));
            end else begin
                chk("no_done", 32'(bus.done_o), 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        cyc = 0;
        last_acc = -1000;
        errors = 0;
        checks = 0;
        rst_ni = 1'b0;
        bus.start_i = 1'b0;
        bus.a_i = '0;
        bus.b_i = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_d", 32'(bus.d_o), 32'd0);
        chk("rst_borrow", 32'(bus.borrow_o), 32'd0);
        chk("rst_ovf", 32'(bus.ovf_o), 32'd0);
        rst_ni = 1'b1;

        issue(16'h1011, 16'h0010, 1'b0);
        issue(16'h0000, 16'h0001, 1'b1);
        issue(16'hFFFF, 16'hFFFF, 1'b1);
        issue(16'h8000, 16'h0001, 1'b1);
        issue(16'h7FFF, 16'hFFFF, 1'b1);

        // Start while busy must be ignored; next start lands on the done cycle.
        issue(16'h0005, 16'h0003, 1'b1);
        repeat (3) @(negedge clk_i);
        issue(16'h0000, 16'h0001, 1'b0);
        issue(16'h1234, 16'h4321, 1'b1);

        // Abort mid-run; outputs must clear at once and no done may follow.
        issue(16'hABCD, 16'h0123, 1'b1);
        @(negedge clk_i);
        while (cyc - last_acc < 8) @(negedge clk_i);
        rst_ni = 1'b0;
        sb.delete();
        last_acc = -1000;
        #1;
        chk("abort_busy", 32'(bus.busy_o), 32'd0);
        chk("abort_done", 32'(bus.done_o), 32'd0);
        chk("abort_d", 32'(bus.d_o), 32'd0);
        chk("abort_borrow", 32'(bus.borrow_o), 32'd0);
        chk("abort_ovf", 32'(bus.ovf_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        issue(16'h0F0F, 16'h00FF, 1'b0);

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            issue(L'($urandom), L'($urandom), 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                issue(L'($urandom), L'($urandom), 1'b0);
            end
        end

        for (int i = 0; i < 4 * L && sb.size() > 0; i++) @(negedge clk_i);
        chk("drain", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
